// File: rtl/mm_pkg.sv
// Shared types for the Mastermind board scheduler: colour codes, board entries and FSM states.
package mm_pkg;

    localparam int MM_MAX_ROWS = 8;

    typedef enum logic [2:0] {
        EMPTY  = 3'd0,
        RED    = 3'd1,
        GREEN  = 3'd2,
        BLUE   = 3'd3,
        ORANGE = 3'd4,
        PURPLE = 3'd5,
        YELLOW = 3'd6
    } colour_t;

    typedef struct packed {
        colour_t    c0;
        colour_t    c1;
        colour_t    c2;
        colour_t    c3;
        logic [2:0] white;
        logic [2:0] black;
    } board_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_COMMIT,
        S_ACK
    } state_t;

endpackage

// File: rtl/mm_slot_tracker.sv
// Pitch counter that maps the LCD x position onto a board slot index.
module mm_slot_tracker
    import mm_pkg::*;
#(
    parameter int ROWS    = MM_MAX_ROWS,
    parameter int X_BASE  = 215,
    parameter int X_PITCH = 100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [10:0] x_pos_i,
    output logic [2:0]  slot_next_o,
    output logic        valid_o
);

    localparam logic [10:0] X_BASE_L  = 11'(X_BASE);
    localparam logic [6:0]  PCNT_LAST = 7'(X_PITCH - 1);
    localparam logic [3:0]  ROWS_L    = 4'(ROWS);

    logic [3:0] slot_q, slot_d;
    logic [6:0] pcnt_q, pcnt_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        slot_d = slot_q;
        pcnt_d = pcnt_q;
        if (x_pos_i == X_BASE_L) begin
            slot_d = '0;
            pcnt_d = '0;
        end else if (slot_q < ROWS_L) begin
            if (pcnt_q == PCNT_LAST) begin
                pcnt_d = '0;
                slot_d = slot_q + 4'd1;
            end else begin
                pcnt_d = pcnt_q + 7'd1;
            end
        end
    end

    // Slot index ROWS is the parked "outside the board" value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_q <= ROWS_L;
            pcnt_q <= '0;
        end else begin
            slot_q <= slot_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign slot_next_o = slot_d[2:0];
    assign valid_o     = (x_pos_i >= X_BASE_L) && (slot_d < ROWS_L);

endmodule

// File: rtl/mm_board_scheduler.sv
// Mastermind board store: vblank-deferred writes/clears via req/ack, per-pixel slot readout.
// Optional MM_ACTIVE_HILITE_EN adds oACTIVE_SLOT marking the next slot to fill.
module mm_board_scheduler
    import mm_pkg::*;
#(
    parameter int ROWS    = 8,
    parameter int X_BASE  = 215,
    parameter int X_PITCH = 100,
    parameter int V_LINE  = 525,
    parameter int V_BP    = 35,
    parameter int V_FP    = 10
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [10:0] iX_POS,
    input  logic [9:0]  iY_POS,
    input  logic        iWR_REQ,
    input  logic [2:0]  iWR_ROW,
    input  logic [2:0]  iWR_C0,
    input  logic [2:0]  iWR_C1,
    input  logic [2:0]  iWR_C2,
    input  logic [2:0]  iWR_C3,
    input  logic [2:0]  iWR_WHITE,
    input  logic [2:0]  iWR_BLACK,
    input  logic        iCLR_REQ,
    output logic        oWR_ACK,
    output logic        oWR_ERR,
    output logic [2:0]  oRVALUE01,
    output logic [2:0]  oRVALUE02,
    output logic [2:0]  oRVALUE03,
    output logic [2:0]  oRVALUE04,
    output logic [2:0]  oWHITE,
    output logic [2:0]  oBLACK,
    output logic        oSLOT_VALID,
    output logic [3:0]  oNR_OF_ROWS
`ifdef MM_ACTIVE_HILITE_EN
    ,
    output logic        oACTIVE_SLOT
`endif
);

    localparam logic [9:0] VB_START = 10'(V_BP);
    localparam logic [9:0] VB_END   = 10'(V_LINE - V_FP);
    localparam logic [3:0] ROWS_L   = 4'(ROWS);

    state_t       state_q, state_d;
    logic         vblank;
    logic         take_req;
    logic [2:0]   sh_row_q;
    board_entry_t sh_entry_q;
    logic         sh_wr_q, sh_clr_q;
    logic         err_q, err_d;
    logic [3:0]   row_ext;
    board_entry_t board_q [MM_MAX_ROWS];
    board_entry_t board_d [MM_MAX_ROWS];
    logic [3:0]   count_q, count_d;

    logic [2:0]   slot_next;
    logic         slot_valid;
    board_entry_t rd_q, rd_d;
    logic         valid_q;

    assign vblank   = (iY_POS < VB_START) || (iY_POS >= VB_END);
    assign take_req = (state_q == S_IDLE) && (iWR_REQ || iCLR_REQ);
    assign row_ext  = {1'b0, sh_row_q};

    always_comb begin
        state_d = state_q;
        board_d = board_q;
        count_d = count_q;
        err_d   = err_q;
        oWR_ACK = 1'b0;
        oWR_ERR = 1'b0;
        case (state_q)
            S_IDLE:   if (take_req) state_d = S_PEND;
            S_PEND:   if (vblank) state_d = S_COMMIT;
            S_COMMIT: begin
                // Clear lands before the write so clear+write leaves exactly one row.
                if (sh_clr_q) begin
                    for (int i = 0; i < MM_MAX_ROWS; i++) board_d[i] = '0;
                    count_d = '0;
                end
                err_d = 1'b0;
                if (sh_wr_q) begin
                    if (row_ext < ROWS_L) begin
                        board_d[sh_row_q] = sh_entry_q;
                        if (row_ext + 4'd1 > count_d) count_d = row_ext + 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                oWR_ACK = 1'b1;
                oWR_ERR = err_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the board is a small flop array, so it is reset like any other register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            sh_row_q   <= '0;
            sh_entry_q <= '0;
            sh_wr_q    <= 1'b0;
            sh_clr_q   <= 1'b0;
            err_q      <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < MM_MAX_ROWS; i++) board_q[i] <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            count_q <= count_d;
            board_q <= board_d;
            if (take_req) begin
                sh_row_q   <= iWR_ROW;
                sh_entry_q <= '{c0: colour_t'(iWR_C0), c1: colour_t'(iWR_C1),
                                c2: colour_t'(iWR_C2), c3: colour_t'(iWR_C3),
                                white: iWR_WHITE, black: iWR_BLACK};
                sh_wr_q    <= iWR_REQ;
                sh_clr_q   <= iCLR_REQ;
            end
        end
    end

    mm_slot_tracker #(
        .ROWS    (ROWS),
        .X_BASE  (X_BASE),
        .X_PITCH (X_PITCH)
    ) u_slot_tracker (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .x_pos_i     (iX_POS),
        .slot_next_o (slot_next),
        .valid_o     (slot_valid)
    );

    always_comb begin
        rd_d = '0;
        if (slot_valid) rd_d = board_q[slot_next];
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            rd_q    <= rd_d;
            valid_q <= slot_valid;
        end
    end

`ifdef MM_ACTIVE_HILITE_EN
    logic active_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) active_q <= 1'b0;
        else      active_q <= slot_valid && ({1'b0, slot_next} == count_q) && (count_q < ROWS_L);
    end

    assign oACTIVE_SLOT = active_q;
`endif

    assign oRVALUE01   = rd_q.c0;
    assign oRVALUE02   = rd_q.c1;
    assign oRVALUE03   = rd_q.c2;
    assign oRVALUE04   = rd_q.c3;
    assign oWHITE      = rd_q.white;
    assign oBLACK      = rd_q.black;
    assign oSLOT_VALID = valid_q;
    assign oNR_OF_ROWS = count_q;

endmodule

// File: tb/tb_mm_board_scheduler.sv
// Directed bench for mm_board_scheduler: a default instance plus a ROWS=7 instance for the error path.
module tb_mm_board_scheduler;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;
    logic        wr_req, clr_req, wr_req7, clr_req7;
    logic [2:0]  wr_row, wc0, wc1, wc2, wc3, wwhite, wblack;

    logic       ack, err, valid;
    logic [2:0] rv0, rv1, rv2, rv3, pw, pb;
    logic [3:0] nrows;
    logic       ack7, err7, valid7;
    logic [2:0] rv7_0, rv7_1, rv7_2, rv7_3, pw7, pb7;
    logic [3:0] nrows7;
`ifdef MM_ACTIVE_HILITE_EN
    logic act, act7;
`endif

    int checks = 0;
    int errors = 0;
    logic [17:0] mb  [8];
    logic [17:0] mb7 [8];
    int mcnt, mcnt7;

    always #5 iCLK = ~iCLK;

    mm_board_scheduler u_dut (
        .iCLK(iCLK), .iRST(iRST), .iX_POS(x_pos), .iY_POS(y_pos),
        .iWR_REQ(wr_req), .iWR_ROW(wr_row),
        .iWR_C0(wc0), .iWR_C1(wc1), .iWR_C2(wc2), .iWR_C3(wc3),
        .iWR_WHITE(wwhite), .iWR_BLACK(wblack), .iCLR_REQ(clr_req),
        .oWR_ACK(ack), .oWR_ERR(err),
        .oRVALUE01(rv0), .oRVALUE02(rv1), .oRVALUE03(rv2), .oRVALUE04(rv3),
        .oWHITE(pw), .oBLACK(pb), .oSLOT_VALID(valid), .oNR_OF_ROWS(nrows)
`ifdef MM_ACTIVE_HILITE_EN
        , .oACTIVE_SLOT(act)
`endif
    );

    mm_board_scheduler #(.ROWS(7)) u_dut7 (
        .iCLK(iCLK), .iRST(iRST), .iX_POS(x_pos), .iY_POS(y_pos),
        .iWR_REQ(wr_req7), .iWR_ROW(wr_row),
        .iWR_C0(wc0), .iWR_C1(wc1), .iWR_C2(wc2), .iWR_C3(wc3),
        .iWR_WHITE(wwhite), .iWR_BLACK(wblack), .iCLR_REQ(clr_req7),
        .oWR_ACK(ack7), .oWR_ERR(err7),
        .oRVALUE01(rv7_0), .oRVALUE02(rv7_1), .oRVALUE03(rv7_2), .oRVALUE04(rv7_3),
        .oWHITE(pw7), .oBLACK(pb7), .oSLOT_VALID(valid7), .oNR_OF_ROWS(nrows7)
`ifdef MM_ACTIVE_HILITE_EN
        , .oACTIVE_SLOT(act7)
`endif
    );

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic set_data(input logic [17:0] e);
        {wc0, wc1, wc2, wc3, wwhite, wblack} = e;
    endtask

    // Full request/ack transaction during vblank on one instance, checked against the board model.
    task automatic do_write(input bit sel7, input bit wr, input bit clr, input logic [2:0] r,
                            input logic [17:0] e, input bit exp_err);
        bit         seen;
        logic       err_s;
        logic [3:0] cnt_s;
        int         rows;
        wr_row = r;
        set_data(e);
        x_pos = '0;
        y_pos = '0;
        if (sel7) begin wr_req7 = wr; clr_req7 = clr; end
        else      begin wr_req  = wr; clr_req  = clr; end
        seen  = 1'b0;
        err_s = 1'b0;
        cnt_s = '0;
        for (int n = 0; n < 12 && !seen; n++) begin
            tick();
            if (sel7 ? ack7 : ack) begin
                seen  = 1'b1;
                err_s = sel7 ? err7 : err;
                cnt_s = sel7 ? nrows7 : nrows;
            end
        end
        wr_req = 1'b0; clr_req = 1'b0; wr_req7 = 1'b0; clr_req7 = 1'b0;
        rows = sel7 ? 7 : 8;
        if (sel7) begin
            if (clr) begin for (int i = 0; i < 8; i++) mb7[i] = '0; mcnt7 = 0; end
            if (wr && int'(r) < rows) begin mb7[r] = e; if (int'(r) + 1 > mcnt7) mcnt7 = int'(r) + 1; end
        end else begin
            if (clr) begin for (int i = 0; i < 8; i++) mb[i] = '0; mcnt = 0; end
            if (wr && int'(r) < rows) begin mb[r] = e; if (int'(r) + 1 > mcnt) mcnt = int'(r) + 1; end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ack_timeout dut7=%0d row=%0d: no ack within 12 cycles", sel7, r);
        end else begin
            checks++;
            if (err_s !== exp_err) begin
                errors++;
                $display("FAIL ack_err dut7=%0d row=%0d: got %b exp %b", sel7, r, err_s, exp_err);
            end
            checks++;
            if (int'(cnt_s) != (sel7 ? mcnt7 : mcnt)) begin
                errors++;
                $display("FAIL row_count dut7=%0d row=%0d: got %0d exp %0d", sel7, r, cnt_s, sel7 ? mcnt7 : mcnt);
            end
        end
        tick();
        checks++;
        if ((sel7 ? ack7 : ack) !== 1'b0) begin
            errors++;
            $display("FAIL ack_one_cycle dut7=%0d: got %b exp 0", sel7, sel7 ? ack7 : ack);
        end
    endtask

    // Sweep one line: output at cycle t+1 describes pixel x(t); slot s spans 215+100s .. 314+100s.
    task automatic sweep(input string tag);
        int          s;
        logic [18:0] got, exp, got7, exp7;
        y_pos = 10'd200;
        for (int xi = 200; xi < 1055; xi++) begin
            x_pos = 11'(xi);
            tick();
            s    = (xi < 215) ? 99 : (xi - 215) / 100;
            got  = {valid, rv0, rv1, rv2, rv3, pw, pb};
            got7 = {valid7, rv7_0, rv7_1, rv7_2, rv7_3, pw7, pb7};
            exp  = '0;
            exp7 = '0;
            if (s < 8) exp  = {1'b1, mb[s]};
            if (s < 7) exp7 = {1'b1, mb7[s]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s pixel x=%0d: got %h exp %h", tag, xi, got, exp);
            end
            checks++;
            if (got7 !== exp7) begin
                errors++;
                $display("FAIL %s pixel_rows7 x=%0d: got %h exp %h", tag, xi, got7, exp7);
            end
`ifdef MM_ACTIVE_HILITE_EN
            checks++;
            if (act !== ((s < 8) && (s == mcnt) && (mcnt < 8))) begin
                errors++;
                $display("FAIL %s active_slot x=%0d: got %b count %0d", tag, xi, act, mcnt);
            end
`endif
        end
    endtask

    task automatic test_reset();
        int acks;
        iRST = 1'b1;
        x_pos = '0; y_pos = '0;
        wr_req = 0; clr_req = 0; wr_req7 = 0; clr_req7 = 0;
        wr_row = '0; set_data('0);
        for (int i = 0; i < 8; i++) begin mb[i] = '0; mb7[i] = '0; end
        mcnt = 0; mcnt7 = 0;
        repeat (3) tick();
        checks++;
        if ({ack, err, rv0, rv1, rv2, rv3, pw, pb, valid, nrows} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h exp 0", {ack, err, rv0, rv1, rv2, rv3, pw, pb, valid, nrows});
        end
        iRST = 1'b0;
        tick();
        do_write(0, 1, 0, 3'd0, {3'd6, 3'd5, 3'd4, 3'd3, 3'd0, 3'd1}, 0);
        // Request raised in active video parks in S_PEND, then reset hits.
        wr_row = 3'd5; set_data({3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1});
        y_pos = 10'd100; wr_req = 1'b1;
        tick(); tick();
        #2 iRST = 1'b1;
        #1;
        checks++;
        if ({ack, err, rv0, rv1, rv2, rv3, pw, pb, valid, nrows} !== 25'd0) begin
            errors++;
            $display("FAIL reset_mid_pend: got %h exp 0", {ack, err, rv0, rv1, rv2, rv3, pw, pb, valid, nrows});
        end
        wr_req = 1'b0;
        tick();
        iRST = 1'b0;
        mb[0] = '0; mcnt = 0;
        y_pos = '0;
        acks = 0;
        repeat (8) begin
            tick();
            if (ack || ack7) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL reset_no_ack: got %0d acks exp 0", acks);
        end
        checks++;
        if (nrows !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d exp 0", nrows);
        end
    endtask

    task automatic test_write_timing();
        wr_row = 3'd2; set_data({3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2});
        x_pos = '0; y_pos = 10'd100; wr_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (ack !== 1'b0) begin errors++; $display("FAIL early_ack y=100 cycle %0d: got %b exp 0", k, ack); end
        end
        y_pos = 10'd514; tick();
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL early_ack y=514: got %b exp 0", ack); end
        y_pos = 10'd515; tick();
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL commit_cycle_ack: got %b exp 0", ack); end
        y_pos = 10'd516; tick();
        checks++;
        if ({ack, err, nrows} !== {1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL write_ack ack/err/count: got %b/%b/%0d exp 1/0/3", ack, err, nrows);
        end
        wr_req = 1'b0; tick();
        checks++;
        if (ack !== 1'b0) begin errors++; $display("FAIL write_ack_pulse: got %b exp 0", ack); end
        mb[2] = {3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2}; mcnt = 3;
        sweep("write_timing");
    endtask

    task automatic test_vblank_edge();
        int acks;
        wr_row = 3'd4; set_data({3'd5, 3'd6, 3'd1, 3'd2, 3'd0, 3'd4});
        x_pos = 11'd1054; y_pos = 10'd34; wr_req = 1'b1;
        acks = 0;
        tick();
        if (ack) acks++;
        x_pos = '0; y_pos = 10'd35;
        repeat (6) begin tick(); if (ack) acks++; end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL vblank_edge_deferred: got %0d acks exp 0", acks); end
        y_pos = 10'd515;
        repeat (8) begin
            tick();
            if (ack) begin acks++; wr_req = 1'b0; end
        end
        wr_req = 1'b0;
        checks++;
        if (acks != 1) begin errors++; $display("FAIL vblank_edge_single_ack: got %0d acks exp 1", acks); end
        checks++;
        if (nrows !== 4'd5) begin errors++; $display("FAIL vblank_edge_count: got %0d exp 5", nrows); end
        mb[4] = {3'd5, 3'd6, 3'd1, 3'd2, 3'd0, 3'd4}; mcnt = 5;
        sweep("vblank_edge");
    endtask

    task automatic test_error();
        do_write(1, 1, 0, 3'd1, {3'd2, 3'd2, 3'd6, 3'd6, 3'd2, 3'd2}, 0);
        do_write(1, 1, 0, 3'd7, {3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0}, 1);
        sweep("error_path");
    endtask

    task automatic test_clear_write();
        do_write(0, 1, 0, 3'd0, {3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0}, 0);
        do_write(0, 1, 0, 3'd1, {3'd3, 3'd4, 3'd5, 3'd6, 3'd2, 3'd1}, 0);
        do_write(0, 1, 0, 3'd3, {3'd6, 3'd5, 3'd4, 3'd3, 3'd0, 3'd0}, 0);
        do_write(0, 1, 0, 3'd5, {3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd1}, 0);
        do_write(0, 1, 0, 3'd6, {3'd4, 3'd4, 3'd1, 3'd5, 3'd1, 3'd3}, 0);
        do_write(0, 1, 0, 3'd7, {3'd5, 3'd1, 3'd6, 3'd2, 3'd0, 3'd4}, 0);
        sweep("board_full");
        do_write(0, 1, 1, 3'd0, {3'd4, 3'd3, 3'd2, 3'd1, 3'd2, 3'd2}, 0);
        sweep("clear_write");
        do_write(0, 0, 1, 3'd3, {3'd6, 3'd6, 3'd6, 3'd6, 3'd4, 3'd4}, 0);
        sweep("clear_only");
    endtask

    task automatic test_slot_boundaries();
        do_write(0, 1, 0, 3'd7, {3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd1}, 0);
        do_write(0, 1, 0, 3'd0, {3'd3, 3'd3, 3'd4, 3'd4, 3'd0, 3'd2}, 0);
        sweep("slot_bounds");
    endtask

    initial begin
        test_reset();
        test_write_timing();
        test_vblank_edge();
        test_error();
        test_clear_write();
        test_slot_boundaries();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
